// File: rtl/ctl_relogio.sv
// Clock control FSM: RUN / SET_H / SET_M with registered counter pulses and blink.
// Optional set-mode idle timeout enabled by defining CTL_TIMEOUT_EN.
module ctl_relogio #(
    parameter int TIMEOUT_TICKS = 30
) (
    input  logic       ctl_clock,
    input  logic       ctl_reset,
    input  logic       ctl_tick,
    input  logic       ctl_btn_mode,
    input  logic       ctl_btn_inc,
    input  logic       ctl_sec_max,
    input  logic       ctl_min_max,
    output logic       ctl_en_s,
    output logic       ctl_en_m,
    output logic       ctl_en_h,
    output logic       ctl_clr_s,
    output logic [1:0] ctl_mode,
    output logic       ctl_blink
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_SET_H = 2'b01;
    localparam logic [1:0] ST_SET_M = 2'b10;

    logic       mode_q;
    logic       inc_q;
    logic       mode_edge;
    logic       inc_edge;
    logic [1:0] state_d;
    logic       en_s_d;
    logic       en_m_d;
    logic       en_h_d;
    logic       clr_d;
    logic       blink_d;
    logic       hold_q;
    logic       hold_d;
    logic       timeout;
    logic       leave;

    assign mode_edge = ctl_btn_mode & ~mode_q;
    assign inc_edge  = ctl_btn_inc & ~inc_q;

`ifdef CTL_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);

    logic [CW-1:0] idle_q;
    logic [CW-1:0] idle_d;

    assign timeout = ctl_tick && (idle_q == CW'(TIMEOUT_TICKS - 1));

    always_comb begin
        idle_d = idle_q;
        if (leave || mode_edge || inc_edge)
            idle_d = '0;
        else if (ctl_tick)
            idle_d = idle_q + 1'b1;
    end

    always_ff @(posedge ctl_clock) begin
        if (!ctl_reset)
            idle_q <= '0;
        else
            idle_q <= idle_d;
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = ctl_mode;
        en_s_d  = 1'b0;
        en_m_d  = 1'b0;
        en_h_d  = 1'b0;
        clr_d   = 1'b0;
        case (ctl_mode)
            ST_RUN: begin
                en_s_d = ctl_tick;
                en_m_d = ctl_tick & ctl_sec_max;
                en_h_d = ctl_tick & ctl_sec_max & ctl_min_max;
                if (mode_edge)
                    state_d = ST_SET_H;
            end
            ST_SET_H: begin
                if (mode_edge)
                    state_d = ST_SET_M;
                else if (inc_edge)
                    en_h_d = 1'b1;
                else if (timeout)
                    state_d = ST_RUN;
            end
            ST_SET_M: begin
                // Leaving minute set restarts seconds at 00.
                if (mode_edge || (!inc_edge && timeout)) begin
                    state_d = ST_RUN;
                    clr_d   = 1'b1;
                end else if (inc_edge) begin
                    en_m_d = 1'b1;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign leave = (state_d != ctl_mode) || (ctl_mode == ST_RUN);

    // An inc edge freezes the blank phase off until the next tick passes.
    always_comb begin
        blink_d = ctl_blink;
        hold_d  = hold_q;
        if (leave) begin
            blink_d = 1'b0;
            hold_d  = 1'b0;
        end else if (inc_edge) begin
            blink_d = 1'b0;
            hold_d  = 1'b1;
        end else if (ctl_tick) begin
            if (hold_q)
                hold_d = 1'b0;
            else
                blink_d = ~ctl_blink;
        end
    end

    always_ff @(posedge ctl_clock) begin
        if (!ctl_reset) begin
            mode_q    <= 1'b1;
            inc_q     <= 1'b1;
            ctl_mode  <= ST_RUN;
            ctl_en_s  <= 1'b0;
            ctl_en_m  <= 1'b0;
            ctl_en_h  <= 1'b0;
            ctl_clr_s <= 1'b0;
            ctl_blink <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            mode_q    <= ctl_btn_mode;
            inc_q     <= ctl_btn_inc;
            ctl_mode  <= state_d;
            ctl_en_s  <= en_s_d;
            ctl_en_m  <= en_m_d;
            ctl_en_h  <= en_h_d;
            ctl_clr_s <= clr_d;
            ctl_blink <= blink_d;
            hold_q    <= hold_d;
        end
    end

endmodule

// File: tb/tb_ctl_relogio.sv
// Bench for ctl_relogio: directed scenarios plus random stimulus
// against a behavioural model of the clock-control rules.
module tb_ctl_relogio;

    localparam int TO = 30;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick;
    logic       bm;
    logic       bi;
    logic       smax;
    logic       mmax;
    logic       en_s;
    logic       en_m;
    logic       en_h;
    logic       clr_s;
    logic [1:0] mode;
    logic       blink;

    int n_chk  = 0;
    int n_pass = 0;

    int m_mode;
    int m_idle;
    int m_since_inc;
    bit m_pm;
    bit m_pi;
    bit m_blink;
    bit e_s;
    bit e_m;
    bit e_h;
    bit e_c;

    int cnt_h;
    int cnt_m;
    int cnt_c;

    always #5 clk = ~clk;

    ctl_relogio #(.TIMEOUT_TICKS(TO)) dut (
        .ctl_clock   (clk),
        .ctl_reset   (rst_n),
        .ctl_tick    (tick),
        .ctl_btn_mode(bm),
        .ctl_btn_inc (bi),
        .ctl_sec_max (smax),
        .ctl_min_max (mmax),
        .ctl_en_s    (en_s),
        .ctl_en_m    (en_m),
        .ctl_en_h    (en_h),
        .ctl_clr_s   (clr_s),
        .ctl_mode    (mode),
        .ctl_blink   (blink)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    endtask

    // m_since_inc: ticks seen since the last accepted inc edge (-1 = none pending)
    task automatic model_update();
        bit me;
        bit ie;
        int nxt;
        bit to;
        if (!rst_n) begin
            m_mode = 0; m_idle = 0; m_since_inc = -1;
            m_pm = 1; m_pi = 1; m_blink = 0;
            e_s = 0; e_m = 0; e_h = 0; e_c = 0;
            return;
        end
        me  = bm && !m_pm;
        ie  = bi && !m_pi;
        e_s = 0; e_m = 0; e_h = 0; e_c = 0;
        nxt = m_mode;
        to  = 0;
`ifdef CTL_TIMEOUT_EN
        to = tick && (m_idle + 1 >= TO);
`endif
        if (m_mode == 0) begin
            e_s = tick;
            e_m = tick && smax;
            e_h = tick && smax && mmax;
            if (me) nxt = 1;
        end else if (me) begin
            nxt = (m_mode + 1) % 3;
            e_c = (m_mode == 2);
        end else if (ie) begin
            if (m_mode == 1) e_h = 1;
            else e_m = 1;
        end else if (to) begin
            nxt = 0;
            e_c = (m_mode == 2);
        end
        if (nxt != m_mode || m_mode == 0) begin
            m_blink = 0; m_since_inc = -1; m_idle = 0;
        end else if (ie || me) begin
            m_blink = 0; m_since_inc = 0; m_idle = 0;
        end else if (tick) begin
            m_idle++;
            if (m_since_inc == 0) m_since_inc = -1;
            else m_blink = !m_blink;
        end
        m_mode = nxt;
        m_pm = bm;
        m_pi = bi;
    endtask

    task automatic step(input bit r, input bit t, input bit b_m,
                        input bit b_i, input bit sm, input bit mm);
        rst_n = r; tick = t; bm = b_m; bi = b_i; smax = sm; mmax = mm;
        @(posedge clk);
        model_update();
        @(negedge clk);
        chk("mode", mode, m_mode);
        chk("en_s", en_s, e_s);
        chk("en_m", en_m, e_m);
        chk("en_h", en_h, e_h);
        chk("clr_s", clr_s, e_c);
        chk("blink", blink, m_blink);
        cnt_h += en_h;
        cnt_m += en_m;
        cnt_c += clr_s;
    endtask

    initial begin
        bit rb;
        bit rt;
        bit rm = 0;
        bit ri = 0;
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        chk("rst_mode", mode, 0);
        step(1, 0, 0, 0, 0, 0);

        step(1, 1, 0, 0, 1, 1);
        chk("carry_s", en_s, 1);
        chk("carry_m", en_m, 1);
        chk("carry_h", en_h, 1);
        step(1, 0, 0, 0, 1, 1);
        chk("carry_end", en_h, 0);

        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        cnt_h = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 1, 0, 0);
            step(1, 1, 0, 0, 1, 1);
        end
        chk("seth_mode", mode, 1);
        chk("seth_pulses", cnt_h, 3);

        cnt_h = 0; cnt_m = 0;
        step(1, 0, 1, 1, 0, 0);
        chk("both_mode", mode, 2);
        step(1, 0, 0, 0, 0, 0);
        chk("both_pulses", cnt_h + cnt_m, 0);

        step(1, 0, 0, 1, 0, 1);
        chk("setm_inc", en_m, 1);
        step(1, 0, 0, 0, 0, 1);
        step(1, 0, 1, 0, 0, 0);
        chk("exit_mode", mode, 0);
        chk("exit_clr", clr_s, 1);
        step(1, 0, 0, 0, 0, 0);
        chk("exit_clr_end", clr_s, 0);

        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        cnt_c = 0;
        for (int i = 0; i < TO; i++) begin
            step(1, 1, 0, 0, 0, 0);
            step(1, 0, 0, 0, 0, 0);
        end
`ifdef CTL_TIMEOUT_EN
        chk("timeout_mode", mode, 0);
        chk("timeout_clr", cnt_c, 1);
`else
        chk("persist_mode", mode, 2);
        chk("persist_clr", cnt_c, 0);
`endif

        step(1, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 0, 0, 0);
        chk("held_rst_mode", mode, 0);
        step(1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 3000; i++) begin
            rb = ($urandom_range(0, 199) != 0);
            rt = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 4) == 0) rm = !rm;
            if ($urandom_range(0, 3) == 0) ri = !ri;
            step(rb, rt, rm, ri, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ctl_relogio.md
CTL_RELOGIO -- requirements
Module: ctl_relogio

Interface
REQ-001 SHALL have parameter TIMEOUT_TICKS, default 30, number of idle 1 Hz ticks before an automatic exit from a set mode (used only with CTL_TIMEOUT_EN).
REQ-002 SHALL have port ctl_clock  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port ctl_reset  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ctl_tick  input  1  one-cycle 1 Hz timebase pulse.
REQ-005 SHALL have port ctl_btn_mode  input  1  debounced mode button level, active-high.
REQ-006 SHALL have port ctl_btn_inc  input  1  debounced increment button level, active-high.
REQ-007 SHALL have port ctl_sec_max  input  1  seconds counter currently at 59.
REQ-008 SHALL have port ctl_min_max  input  1  minutes counter currently at 59.
REQ-009 SHALL have port ctl_en_s  output  1  seconds counter enable pulse.
REQ-010 SHALL have port ctl_en_m  output  1  minutes counter enable pulse.
REQ-011 SHALL have port ctl_en_h  output  1  hours counter enable pulse.
REQ-012 SHALL have port ctl_clr_s  output  1  seconds counter clear pulse.
REQ-013 SHALL have port ctl_mode  output  2  current state: 00 RUN, 01 SET_H, 10 SET_M.
REQ-014 SHALL have port ctl_blink  output  1  display blink phase, 1 = digits of the field being set are blanked.

Function
REQ-015 SHALL implement a three-state FSM: RUN -> SET_H -> SET_M -> RUN, advancing one state per rising edge of ctl_btn_mode; 11 SHALL never be reached and SHALL recover to RUN.
REQ-016 SHALL detect a button edge as level high this cycle and low in the registered previous sample.
REQ-017 SHALL register all outputs; each enable/clear pulse SHALL be exactly one cycle wide and SHALL appear the cycle after its cause (tick or edge).
REQ-018 In RUN, each ctl_tick SHALL pulse ctl_en_s; it SHALL also pulse ctl_en_m if ctl_sec_max=1, and ctl_en_h if ctl_sec_max=1 and ctl_min_max=1, all in the same cycle.
REQ-019 In SET_H, ctl_en_s and ctl_en_m SHALL be 0; each ctl_btn_inc edge SHALL pulse ctl_en_h only.
REQ-020 In SET_M, ctl_en_s and ctl_en_h SHALL be 0; each ctl_btn_inc edge SHALL pulse ctl_en_m only, with no carry into hours when ctl_min_max=1.
REQ-021 The SET_M -> RUN transition SHALL pulse ctl_clr_s once, so seconds restart at 00.
REQ-022 ctl_btn_inc edges in RUN SHALL be ignored.
REQ-023 A mode edge and an inc edge in the same cycle: the mode transition SHALL occur and the inc edge SHALL be discarded.
REQ-024 ctl_blink SHALL be 0 in RUN, SHALL toggle on every ctl_tick in SET_H/SET_M, and SHALL be forced to 0 on every state change and for one tick after any inc edge.
REQ-025 A button held steadily high SHALL produce exactly one edge, regardless of duration.

Reset
REQ-026 With ctl_reset=0 at a clock edge: state RUN, ctl_mode=00, all enable/clear outputs 0, ctl_blink=0, timeout counter 0.
REQ-027 The registered button samples SHALL reset to 1, so a button held through reset release SHALL produce no edge.
REQ-028 Reset asserted mid-set-mode SHALL abandon the mode without pulsing ctl_clr_s.

Configuration
REQ-029 With macro CTL_TIMEOUT_EN defined, SET_H/SET_M SHALL count ctl_tick pulses, clear the count on any inc or mode edge, and on reaching TIMEOUT_TICKS go to RUN (pulsing ctl_clr_s if leaving SET_M).
REQ-030 Without CTL_TIMEOUT_EN, no timeout counter SHALL exist and set modes SHALL persist indefinitely.

Verification
REQ-031 RUN, ctl_sec_max=1, ctl_min_max=1, ctl_tick pulse at cycle N -> ctl_en_s, ctl_en_m, ctl_en_h all 1 at N+1 only.
REQ-032 Mode edge, then 3 inc edges -> ctl_mode=01, exactly 3 ctl_en_h pulses, ctl_en_s stays 0 across intervening ticks.
REQ-033 From SET_M, mode edge -> ctl_mode=00, single ctl_clr_s pulse the next cycle.
REQ-034 Mode and inc rising in the same cycle while in SET_H -> ctl_mode=10, no ctl_en_h/ctl_en_m pulse.
REQ-035 ctl_btn_mode held high through reset release -> ctl_mode remains 00.
REQ-036 CTL_TIMEOUT_EN defined, TIMEOUT_TICKS=30, enter SET_M, no buttons, 30 ticks -> ctl_mode=00 and one ctl_clr_s pulse; macro undefined -> ctl_mode stays 10.
